// File: rtl/score4_turn_ctrl.sv
// rtl/score4_turn_ctrl.sv - score4 game-flow sequencer (optional cursor wrap: SCORE4_CURSOR_WRAP_EN)
module score4_turn_ctrl #(
  parameter int COLS = 7,
  parameter int ROWS = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       left,
  input  logic       right,
  input  logic       put,
  output logic       wr_req,
  input  logic       wr_ack,
  output logic [2:0] wr_row,
  output logic [2:0] wr_col,
  output logic [1:0] wr_val,
  output logic       chk_start,
  input  logic       chk_done,
  input  logic       chk_win,
  input  logic       chk_full,
  output logic [2:0] cursor_col,
  output logic       player,
  output logic       invalid_move,
  output logic       win_a,
  output logic       win_b,
  output logic       full_panel,
  output logic       busy
);

  localparam logic [2:0] LAST_COL = 3'(COLS - 1);
  localparam logic [2:0] TOP_ROW  = 3'(ROWS);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WRITE    = 3'd1,
    CHECK    = 3'd2,
    WAIT_CHK = 3'd3,
    OVER     = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] cursor_q, cursor_d;
  logic [2:0] height_q [COLS];
  logic [2:0] height_d [COLS];
  logic       player_q, player_d;
  logic       invalid_q, invalid_d;
  logic       win_a_q, win_a_d;
  logic       win_b_q, win_b_d;
  logic       full_q, full_d;
  logic       left_q, right_q, put_q;
  logic       left_rise, right_rise, put_rise;

  assign left_rise  = left  & ~left_q;
  assign right_rise = right & ~right_q;
  assign put_rise   = put   & ~put_q;

  // State, game status and button history registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cursor_q  <= 3'd0;
      player_q  <= 1'b0;
      invalid_q <= 1'b0;
      win_a_q   <= 1'b0;
      win_b_q   <= 1'b0;
      full_q    <= 1'b0;
      left_q    <= 1'b0;
      right_q   <= 1'b0;
      put_q     <= 1'b0;
      for (int i = 0; i < COLS; i++) height_q[i] <= 3'd0;
    end else begin
      state_q   <= state_d;
      cursor_q  <= cursor_d;
      player_q  <= player_d;
      invalid_q <= invalid_d;
      win_a_q   <= win_a_d;
      win_b_q   <= win_b_d;
      full_q    <= full_d;
      left_q    <= left;
      right_q   <= right;
      put_q     <= put;
      for (int i = 0; i < COLS; i++) height_q[i] <= height_d[i];
    end
  end

  // Next-state logic: button moves in IDLE, then write / check handshakes
  always_comb begin
    state_d   = state_q;
    cursor_d  = cursor_q;
    player_d  = player_q;
    invalid_d = invalid_q;
    win_a_d   = win_a_q;
    win_b_d   = win_b_q;
    full_d    = full_q;
    height_d  = height_q;
    case (state_q)
      IDLE: begin
        // put beats right beats left when rises coincide
        if (put_rise) begin
          if (height_q[cursor_q] == TOP_ROW) begin
            invalid_d = 1'b1;
          end else begin
            invalid_d = 1'b0;
            state_d   = WRITE;
          end
        end else if (right_rise) begin
          if (cursor_q < LAST_COL) begin
            cursor_d  = cursor_q + 3'd1;
            invalid_d = 1'b0;
          end else begin
`ifdef SCORE4_CURSOR_WRAP_EN
            cursor_d  = 3'd0;
            invalid_d = 1'b0;
`else
            invalid_d = 1'b1;
`endif
          end
        end else if (left_rise) begin
          if (cursor_q != 3'd0) begin
            cursor_d  = cursor_q - 3'd1;
            invalid_d = 1'b0;
          end else begin
`ifdef SCORE4_CURSOR_WRAP_EN
            cursor_d  = LAST_COL;
            invalid_d = 1'b0;
`else
            invalid_d = 1'b1;
`endif
          end
        end
      end
      WRITE: begin
        if (wr_ack) begin
          height_d[cursor_q] = height_q[cursor_q] + 3'd1;
          state_d            = CHECK;
        end
      end
      CHECK: state_d = WAIT_CHK;
      WAIT_CHK: begin
        // a win outranks a simultaneous full-panel report
        if (chk_done) begin
          if (chk_win) begin
            if (player_q) win_b_d = 1'b1;
            else          win_a_d = 1'b1;
            state_d = OVER;
          end else if (chk_full) begin
            full_d  = 1'b1;
            state_d = OVER;
          end else begin
            player_d = ~player_q;
            state_d  = IDLE;
          end
        end
      end
      OVER:    state_d = OVER;
      default: state_d = IDLE;
    endcase
  end

  assign wr_req       = (state_q == WRITE);
  assign wr_row       = wr_req ? height_q[cursor_q] : 3'd0;
  assign wr_col       = wr_req ? cursor_q : 3'd0;
  assign wr_val       = wr_req ? (player_q ? 2'b10 : 2'b01) : 2'b00;
  assign chk_start    = (state_q == CHECK);
  assign cursor_col   = cursor_q;
  assign player       = player_q;
  assign invalid_move = invalid_q;
  assign win_a        = win_a_q;
  assign win_b        = win_b_q;
  assign full_panel   = full_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_score4_turn_ctrl.sv
// tb/tb_score4_turn_ctrl.sv - scoreboard bench for score4_turn_ctrl
module tb_score4_turn_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       left = 1'b0, right = 1'b0, put = 1'b0;
  logic       wr_req, wr_ack = 1'b0;
  logic [2:0] wr_row, wr_col;
  logic [1:0] wr_val;
  logic       chk_start, chk_done = 1'b0, chk_win = 1'b0, chk_full = 1'b0;
  logic [2:0] cursor_col;
  logic       player, invalid_move, win_a, win_b, full_panel, busy;

  typedef struct {
    int row;
    int col;
    int val;
    int hold;
  } wr_exp_t;

  wr_exp_t sb_q[$];
  int n_pass = 0;
  int n_total = 0;
  int ack_delay = 0;
  bit resp_win = 1'b0;
  bit resp_full = 1'b0;

  score4_turn_ctrl #(.COLS(7), .ROWS(6)) dut (
    .clk(clk), .rst(rst), .left(left), .right(right), .put(put),
    .wr_req(wr_req), .wr_ack(wr_ack), .wr_row(wr_row), .wr_col(wr_col), .wr_val(wr_val),
    .chk_start(chk_start), .chk_done(chk_done), .chk_win(chk_win), .chk_full(chk_full),
    .cursor_col(cursor_col), .player(player), .invalid_move(invalid_move),
    .win_a(win_a), .win_b(win_b), .full_panel(full_panel), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Panel register file and win checker stand-in
  initial begin
    int wr_wait;
    bit chk_pend;
    wr_wait  = 0;
    chk_pend = 1'b0;
    forever begin
      @(negedge clk);
      wr_ack = 1'b0; chk_done = 1'b0; chk_win = 1'b0; chk_full = 1'b0;
      if (rst) begin
        wr_wait  = 0;
        chk_pend = 1'b0;
      end else begin
        if (chk_pend) begin
          chk_done = 1'b1; chk_win = resp_win; chk_full = resp_full; chk_pend = 1'b0;
        end
        if (chk_start) chk_pend = 1'b1;
        if (wr_req) begin
          if (wr_wait >= ack_delay) begin wr_ack = 1'b1; wr_wait = 0; end
          else wr_wait++;
        end else wr_wait = 0;
      end
    end
  end

  // Monitor: compares every accepted write and the chk_start pulse that follows it
  initial begin
    int run;
    int exp_chk;
    wr_exp_t e;
    run = 0;
    exp_chk = 0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        run = 0;
        exp_chk = 0;
      end else begin
        if (exp_chk == 2) begin check("chk_start_one_cycle", chk_start, 0); exp_chk = 0; end
        if (exp_chk == 1) begin check("chk_start_after_ack", chk_start, 1); exp_chk = 2; end
        if (wr_req) begin
          run++;
          if (wr_ack) begin
            if (sb_q.size() == 0) begin
              n_total++;
              $display("FAIL unexpected_write: row %0d col %0d, no write expected", wr_row, wr_col);
            end else begin
              e = sb_q.pop_front();
              check("wr_row", int'(wr_row), e.row);
              check("wr_col", int'(wr_col), e.col);
              check("wr_val", int'(wr_val), e.val);
              check("wr_req_hold", run, e.hold);
            end
            run = 0;
            exp_chk = 1;
          end
        end else run = 0;
      end
    end
  end

  task automatic press(input bit l, input bit r, input bit p);
    @(negedge clk);
    left = l; right = r; put = p;
    @(negedge clk);
    left = 1'b0; right = 1'b0; put = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; left = 1'b0; right = 1'b0; put = 1'b0;
    sb_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Waits for IDLE or an end-of-game flag, bounded
  task automatic wait_settle(input string name);
    int n;
    n = 0;
    while (busy && !win_a && !win_b && !full_panel && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_total++;
      $display("FAIL %s: timed out after %0d cycles, required settle", name, n);
    end
  endtask

  function automatic push_wr(input int row, input int col, input int val, input int hold);
    wr_exp_t e;
    e.row = row; e.col = col; e.val = val; e.hold = hold;
    sb_q.push_back(e);
  endfunction

  initial begin
    int exp_cur;
    int exp_inv;
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_cur;
    int exp_inv;

    // 1: reset state and cursor range
    do_reset();
    check("rst_cursor", int'(cursor_col), 0);
    check("rst_player", int'(player), 0);
    check("rst_invalid", int'(invalid_move), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_wr_req", int'(wr_req), 0);
    check("rst_chk_start", int'(chk_start), 0);
    check("rst_flags", int'({win_a, win_b, full_panel}), 0);
    exp_cur = 0;
    for (int i = 1; i <= 8; i++) begin
      press(1'b0, 1'b1, 1'b0);
      if (exp_cur < 6) begin exp_cur++; exp_inv = 0; end
`ifdef SCORE4_CURSOR_WRAP_EN
      else begin exp_cur = 0; exp_inv = 0; end
`else
      else exp_inv = 1;
`endif
      check("right_cursor", int'(cursor_col), exp_cur);
      check("right_invalid", int'(invalid_move), exp_inv);
    end
    press(1'b1, 1'b0, 1'b0);
    exp_cur = (exp_cur == 0) ? 6 : exp_cur - 1;
    check("left_cursor", int'(cursor_col), exp_cur);
    check("left_invalid", int'(invalid_move), 0);

    // 2: fill column 0, seventh put rejected
    do_reset();
    ack_delay = 0; resp_win = 1'b0; resp_full = 1'b0;
    for (int i = 0; i < 6; i++) begin
      push_wr(i, 0, (i % 2 == 1) ? 2 : 1, 1);
      press(1'b0, 1'b0, 1'b1);
      wait_settle("fill_settle");
      check("fill_invalid", int'(invalid_move), 0);
    end
    press(1'b0, 1'b0, 1'b1);
    check("full_col_invalid", int'(invalid_move), 1);
    check("full_col_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    check("full_col_player", int'(player), 0);
    check("full_col_no_write", sb_q.size(), 0);

    // 3: delayed write acknowledge
    do_reset();
    ack_delay = 4;
    push_wr(0, 0, 1, 5);
    press(1'b0, 1'b0, 1'b1);
    check("put_wr_req_next", int'(wr_req), 1);
    wait_settle("slow_ack_settle");
    check("slow_ack_player", int'(player), 1);

    // 4: player B wins, game frozen
    ack_delay = 0; resp_win = 1'b1;
    press(1'b0, 1'b1, 1'b0);
    push_wr(0, 1, 2, 1);
    press(1'b0, 1'b0, 1'b1);
    wait_settle("win_b_settle");
    @(negedge clk);
    check("win_b", int'(win_b), 1);
    check("win_b_win_a", int'(win_a), 0);
    check("win_b_busy", int'(busy), 1);
    press(1'b0, 1'b0, 1'b1);
    press(1'b0, 1'b1, 1'b0);
    check("over_wr_req", int'(wr_req), 0);
    check("over_cursor", int'(cursor_col), 1);
    check("over_player", int'(player), 1);
    check("over_busy", int'(busy), 1);

    // 5: win and full together at player A
    do_reset();
    resp_win = 1'b1; resp_full = 1'b1;
    push_wr(0, 0, 1, 1);
    press(1'b0, 1'b0, 1'b1);
    wait_settle("win_a_settle");
    check("win_a", int'(win_a), 1);
    check("win_a_full", int'(full_panel), 0);
    check("win_a_win_b", int'(win_b), 0);

    // 6: reset during WRITE, then coincident put+right
    do_reset();
    resp_win = 1'b0; resp_full = 1'b0; ack_delay = 20;
    press(1'b0, 1'b0, 1'b1);
    check("pre_rst_wr_req", int'(wr_req), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_wr_req", int'(wr_req), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_chk_start", int'(chk_start), 0);
    rst = 1'b0;
    ack_delay = 0;
    push_wr(0, 0, 1, 1);
    press(1'b0, 1'b1, 1'b1);
    wait_settle("put_right_settle");
    check("put_right_cursor", int'(cursor_col), 0);
    check("put_right_player", int'(player), 1);
    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
